// File: rtl/freq_cmp_pkg.sv
// ============================================================================
//  Module      : freq_cmp_pkg
//  Description : Shared types and constants for the freq_cmp_cal block.
//                - state_t : measurement FSM state (IDLE, CAL, RUN)
//                - UD_*    : encodings of the 2-bit glissando command
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package freq_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] UD_HOLD = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

endpackage

`default_nettype wire

// File: rtl/freq_cmp_cal_sync_edge_det.sv
// ============================================================================
//  Module      : sync_edge_det
//  Description : Two-flop synchronizer for the asynchronous oscillator square
//                wave plus a registered rising-edge pulse.
//  Ports       : clk        - system clock
//                reset_n    - asynchronous active-low reset
//                square_in  - raw square wave (asynchronous to clk)
//                square_out - synchronized square wave (second flop)
//                edge_pulse - one-cycle pulse, 3 clk after square_in rises
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic square_in,
    output logic square_out,
    output logic edge_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= square_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            // Edge flag is registered once more so the counter sees a clean
            // flop output rather than a decode of the synchronizer chain.
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    assign square_out = r_sync2;
    assign edge_pulse = r_edge;

endmodule

`default_nettype wire

// File: rtl/freq_cmp_cal.sv
// ============================================================================
//  Module      : freq_cmp_cal
//  Description : Counts antenna-oscillator edges over a fixed gate window,
//                calibrates a baseline on request and then reports up/down
//                glissando commands relative to that baseline.
//  Ports       : clk          - system clock
//                reset_n      - asynchronous active-low reset
//                square_in    - raw oscillator square wave (asynchronous)
//                cal_start    - single-cycle pulse, starts calibration
//                square_out   - synchronized square wave
//                freq_up_down - 01 up, 10 down, 00 hold
//                cal_done     - high while a valid baseline exists
//                count_out    - edge count of the last completed window
//                window_done  - one-cycle pulse when results update
//  Options     : FREQ_CMP_CAL_AVG_EN - when defined, calibration averages four
//                consecutive windows instead of using a single window.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_cmp_cal
    import freq_cmp_pkg::*;
#(
    parameter int GATE_CYCLES = 1048576,
    parameter int CNT_W       = 16,
    parameter int HYST        = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             square_in,
    input  logic             cal_start,
    output logic             square_out,
    output logic [1:0]       freq_up_down,
    output logic             cal_done,
    output logic [CNT_W-1:0] count_out,
    output logic             window_done
);

    localparam int                 c_win_w    = $clog2(GATE_CYCLES);
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(GATE_CYCLES - 1);
    localparam logic [c_win_w-1:0] c_win_one  = c_win_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
    localparam logic [CNT_W:0]     c_cmp_max  = {1'b0, c_cnt_max};
    localparam logic [CNT_W:0]     c_hyst     = (CNT_W + 1)'(HYST);

    state_t             r_state;
    state_t             w_next_state;
    logic [c_win_w-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]   r_baseline;
    logic               w_edge_pulse;

    // FSM-decoded strobes
    logic w_counting;
    logic w_close;
    logic w_start_window;
    logic w_abort;
    logic w_cal_close;
    logic w_cal_last_close;
    logic w_run_close;

    // Datapath results
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_count_ext;
    logic [CNT_W:0]   w_base_ext;
    logic [CNT_W:0]   w_hi_sum;
    logic [CNT_W:0]   w_hi;
    logic [CNT_W:0]   w_lo;
    logic [1:0]       w_ud;

    sync_edge_det u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .square_in  (square_in),
        .square_out (square_out),
        .edge_pulse (w_edge_pulse)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (cal_start)        w_next_state = ST_CAL;
            ST_CAL:  if (w_cal_last_close) w_next_state = ST_RUN;
            ST_RUN:  if (cal_start)        w_next_state = ST_CAL;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
`ifdef FREQ_CMP_CAL_AVG_EN
    logic [1:0]       r_cal_idx;
    logic [CNT_W+1:0] r_acc;
    logic [CNT_W+1:0] w_acc_sum;

    assign w_acc_sum = r_acc + {2'b00, w_count};
`endif

    always_comb begin
        w_counting       = (r_state != ST_IDLE);
        w_close          = w_counting && (r_win_cnt == c_win_last);
        w_start_window   = cal_start && (r_state != ST_CAL);
        w_abort          = cal_start && (r_state == ST_RUN);
        w_cal_close      = w_close && (r_state == ST_CAL);
`ifdef FREQ_CMP_CAL_AVG_EN
        w_cal_last_close = w_cal_close && (r_cal_idx == 2'd3);
`else
        w_cal_last_close = w_cal_close;
`endif
        // A recalibration request beats a coincident window close.
        w_run_close      = w_close && (r_state == ST_RUN) && !cal_start;
    end

    // ------------------------------------------------------------------
    // Window and edge counters
    // ------------------------------------------------------------------
    // Count including an edge arriving in the current cycle, saturating.
    assign w_count = (r_edge_cnt == c_cnt_max) ? c_cnt_max
                                               : r_edge_cnt + CNT_W'(w_edge_pulse);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (!w_counting || w_start_window || w_close) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_win_cnt  <= r_win_cnt + c_win_one;
            r_edge_cnt <= w_count;
        end
    end

    // ------------------------------------------------------------------
    // Baseline comparison at CNT_W+1 bits: upper threshold clamps to the
    // counter maximum, lower threshold floors at zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_ext = {1'b0, w_count};
        w_base_ext  = {1'b0, r_baseline};
        w_hi_sum    = w_base_ext + c_hyst;
        w_hi        = (w_hi_sum > c_cmp_max) ? c_cmp_max : w_hi_sum;
        w_lo        = (w_base_ext >= c_hyst) ? (w_base_ext - c_hyst) : '0;
        w_ud        = UD_HOLD;
        if (w_count_ext > w_hi) begin
            w_ud = UD_UP;
        end else if (w_count_ext < w_lo) begin
            w_ud = UD_DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baseline   <= '0;
            count_out    <= '0;
            freq_up_down <= UD_HOLD;
            cal_done     <= 1'b0;
            window_done  <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (w_abort) begin
                cal_done     <= 1'b0;
                freq_up_down <= UD_HOLD;
            end else if (w_cal_close) begin
                count_out   <= w_count;
                window_done <= 1'b1;
`ifdef FREQ_CMP_CAL_AVG_EN
                if (w_cal_last_close) begin
                    r_baseline <= w_acc_sum[CNT_W+1:2];
                    cal_done   <= 1'b1;
                end
`else
                r_baseline  <= w_count;
                cal_done    <= 1'b1;
`endif
            end else if (w_run_close) begin
                count_out    <= w_count;
                freq_up_down <= w_ud;
                window_done  <= 1'b1;
            end
        end
    end

`ifdef FREQ_CMP_CAL_AVG_EN
    // Averaging accumulator: cleared whenever a calibration begins, summed
    // over the four calibration windows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cal_idx <= '0;
            r_acc     <= '0;
        end else if (w_start_window) begin
            r_cal_idx <= '0;
            r_acc     <= '0;
        end else if (w_cal_close) begin
            r_cal_idx <= r_cal_idx + 2'd1;
            r_acc     <= w_cal_last_close ? '0 : w_acc_sum;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_cmp_cal.sv
// ============================================================================
//  Module      : tb_freq_cmp_cal
//  Description : Self-checking bench for freq_cmp_cal. A timestamp-based model
//                predicts every output each cycle; directed phases pin the
//                model and the boundary cases with hand-computed values, and
//                a second instance with a narrow counter covers saturation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_freq_cmp_cal;

    localparam int G    = 1000;
    localparam int W    = 8;
    localparam int H    = 2;
    localparam int W6   = 6;
    localparam int CMAX = (1 << W) - 1;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          square_in = 1'b0;
    logic          cal_start = 1'b0;
    logic          square_out;
    logic [1:0]    freq_up_down;
    logic          cal_done;
    logic [W-1:0]  count_out;
    logic          window_done;
    logic          sqo6;
    logic [1:0]    fud6;
    logic          cd6;
    logic [W6-1:0] cnt6;
    logic          wd6;

    always #5 clk = ~clk;

    freq_cmp_cal #(.GATE_CYCLES(G), .CNT_W(W), .HYST(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .square_in    (square_in),
        .cal_start    (cal_start),
        .square_out   (square_out),
        .freq_up_down (freq_up_down),
        .cal_done     (cal_done),
        .count_out    (count_out),
        .window_done  (window_done)
    );

    freq_cmp_cal #(.GATE_CYCLES(G), .CNT_W(W6), .HYST(H)) dut6 (
        .clk          (clk),
        .reset_n      (reset_n),
        .square_in    (square_in),
        .cal_start    (cal_start),
        .square_out   (sqo6),
        .freq_up_down (fud6),
        .cal_done     (cd6),
        .count_out    (cnt6),
        .window_done  (wd6)
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ------------------------------------------------------------------
    // Square wave source: period in clk cycles, high for the first half.
    // ------------------------------------------------------------------
    int period = 20;
    int phase  = 0;
    always @(negedge clk) begin
        phase = phase + 1;
        if (phase >= period) phase = 0;
        square_in = (phase < period / 2);
    end

    // ------------------------------------------------------------------
    // Reference model. Each rising edge of square_in seen at clock n is
    // credited at clock n+3; a window started at clock s closes at clock
    // s+G and holds every credit timestamped in (s, s+G].
    // ------------------------------------------------------------------
    int   n      = 0;
    int   mode   = 0;          // 0 idle, 1 calibrating, 2 running
    int   wstart = 0;
    int   base   = 0;
    int   credit_q[$];
    logic m_d1   = 1'b0;
    logic m_d2   = 1'b0;
    int   m_count = 0;
    int   m_ud    = 0;
    int   m_wd    = 0;
    int   m_cal   = 0;

    function automatic int take_upto(input int t);
        int c = 0;
        while (credit_q.size() > 0 && credit_q[0] <= t) begin
            void'(credit_q.pop_front());
            c++;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        int c;
        int hi;
        int lo;
        n = n + 1;
        if (!reset_n) begin
            mode = 0; base = 0; credit_q.delete();
            m_d1 = 1'b0; m_d2 = 1'b0;
            m_count = 0; m_ud = 0; m_wd = 0; m_cal = 0;
        end else begin
            if (square_in && !m_d1) credit_q.push_back(n + 3);
            m_d2 = m_d1;
            m_d1 = square_in;
            m_wd = 0;
            if (mode == 0) begin
                c = take_upto(n);
                if (cal_start) begin mode = 1; wstart = n; end
            end else if (mode == 2 && cal_start) begin
                c = take_upto(n);
                mode = 1; wstart = n; m_cal = 0; m_ud = 0;
            end else if (n == wstart + G) begin
                c = take_upto(n);
                if (c > CMAX) c = CMAX;
                m_count = c;
                m_wd    = 1;
                if (mode == 1) begin
                    base = c; m_cal = 1; mode = 2;
                end else begin
                    hi = (base + H > CMAX) ? CMAX : base + H;
                    lo = (base >= H) ? base - H : 0;
                    m_ud = (c > hi) ? 1 : (c < lo) ? 2 : 0;
                end
                wstart = n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model, on the inactive edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset_n) begin
            cmp("rst_count_out", int'(count_out), 0);
            cmp("rst_freq_up_down", int'(freq_up_down), 0);
            cmp("rst_window_done", int'(window_done), 0);
            cmp("rst_cal_done", int'(cal_done), 0);
            cmp("rst_square_out", int'(square_out), 0);
        end else begin
            cmp("count_out", int'(count_out), m_count);
            cmp("freq_up_down", int'(freq_up_down), m_ud);
            cmp("window_done", int'(window_done), m_wd);
            cmp("cal_done", int'(cal_done), m_cal);
            cmp("square_out", int'(square_out), int'(m_d2));
        end
    end

    task automatic wait_wd(input string tag, input int limit);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!window_done && k < limit);
        if (!window_done) begin
            total++;
            bad++;
            $display("FAIL %s: window_done=0 after %0d cycles, expected 1", tag, limit);
        end
    endtask

    task automatic pulse_cal();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nwd;
        repeat (4) @(negedge clk);
        // Reset state
        cmp("reset_count_out", int'(count_out), 0);
        cmp("reset_cal_done", int'(cal_done), 0);
        cmp("reset_fud", int'(freq_up_down), 0);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);

        // Calibration at period 20 -> 50 edges per window
        period = 20;
        pulse_cal();
        wait_wd("cal", G + 10);
        cmp("cal_count_out", int'(count_out), 50);
        cmp("cal_model_count", m_count, 50);
        cmp("cal_cal_done", int'(cal_done), 1);
        cmp("cal_fud", int'(freq_up_down), 0);
        cmp("cal6_count_out", int'(cnt6), 50);

        // Up: period 16
        period = 16;
        wait_wd("up_a", G + 10);
        wait_wd("up_b", G + 10);
        cmp_range("up_count_out", int'(count_out), 62, 63);
        cmp("up_fud", int'(freq_up_down), 1);

        // Down: period 25
        period = 25;
        wait_wd("dn_a", G + 10);
        wait_wd("dn_b", G + 10);
        cmp("dn_count_out", int'(count_out), 40);
        cmp("dn_fud", int'(freq_up_down), 2);

        // Dead-band: period 20
        period = 20;
        wait_wd("db_a", G + 10);
        for (int i = 0; i < 2; i++) begin
            wait_wd("db_b", G + 10);
            cmp_range("db_count_out", int'(count_out), 49, 51);
            cmp("db_fud", int'(freq_up_down), 0);
        end

        // Saturation: period 4 -> 250 edges, 6-bit instance clamps at 63
        period = 4;
        wait_wd("sat_a", G + 10);
        wait_wd("sat_b", G + 10);
        cmp("sat6_count_out", int'(cnt6), 63);
        cmp("sat6_fud", int'(fud6), 1);
        cmp("sat_count_out", int'(count_out), 250);

        // Recalibration mid-window
        period = 20;
        wait_wd("rc_a", G + 10);
        wait_wd("rc_b", G + 10);
        repeat (499) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        cmp("rc_cal_done", int'(cal_done), 0);
        cmp("rc_fud", int'(freq_up_down), 0);
        nwd = 0;
        repeat (995) begin
            @(negedge clk);
            if (window_done) nwd++;
        end
        cmp("rc_no_window_done", nwd, 0);
        wait_wd("rc_new", 20);
        cmp("rc_count_out", int'(count_out), 50);
        cmp("rc_cal_done_again", int'(cal_done), 1);

        // cal_start coincident with a RUN window close
        repeat (999) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        cmp("coinc_window_done", int'(window_done), 0);
        cmp("coinc_cal_done", int'(cal_done), 0);
        wait_wd("coinc_new", G + 10);
        cmp("coinc_count_out", int'(count_out), 50);

        // Asynchronous reset mid-window in RUN
        wait_wd("rst_a", G + 10);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        cmp("arst_cal_done", int'(cal_done), 0);
        cmp("arst_count_out", int'(count_out), 0);
        cmp("arst_fud", int'(freq_up_down), 0);
        cmp("arst_window_done", int'(window_done), 0);
        cmp("arst_square_out", int'(square_out), 0);
        cmp("arst6_cal_done", int'(cd6), 0);
        cmp("arst6_wd_sq", int'(wd6) + int'(sqo6), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nwd = 0;
        repeat (2500) begin
            @(negedge clk);
            if (window_done) nwd++;
        end
        cmp("idle_no_window_done", nwd, 0);
        cmp("idle_cal_done", int'(cal_done), 0);

        // Randomized segments with occasional cal_start pulses
        pulse_cal();
        for (int seg = 0; seg < 12; seg++) begin
            int len;
            period = $urandom_range(6, 40);
            len    = $urandom_range(300, 2500);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                cal_start = ($urandom_range(0, 599) == 0);
            end
            @(negedge clk);
            cal_start = 1'b0;
        end
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
